// File: rtl/useq_pkg.sv
// Shared constants and next-address mode encodings for the micro-sequencer.
package useq_pkg;

  localparam int ADDR_W_DEF      = 6;
  localparam int NUM_COND_DEF    = 8;
  localparam int OPC_W_DEF       = 4;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int RESET_ADDR_DEF  = 18;

  typedef enum logic [2:0] {
    MODE_JUMP     = 3'b000,
    MODE_COND     = 3'b001,
    MODE_DISPATCH = 3'b010,
    MODE_CALL     = 3'b011,
    MODE_RET      = 3'b100
  } mode_e;

endpackage

// File: rtl/useq_stack.sv
// Return-address stack: push/pop with occupancy count and full/empty status.
module useq_stack #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              top,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W:0]    top_idx;

  assign full    = (depth == (PTR_W+1)'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign top_idx = depth - (PTR_W+1)'(1);
  assign top     = empty ? '0 : mem[top_idx[PTR_W-1:0]];

  // Overflowing pushes and underflowing pops are dropped; the caller flags them.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[depth[PTR_W-1:0]] <= push_data;
      depth                 <= depth + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      depth <= depth - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/micro_pc_unit.sv
// Micro-program counter: next-address selection (jump/cond/dispatch/call/ret)
// with a return stack and sticky stack-error flags.
module micro_pc_unit
  import useq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_COND    = NUM_COND_DEF,
  parameter int OPC_W       = OPC_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int RESET_ADDR  = RESET_ADDR_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_stall,
  input  logic [2:0]                    i_mode,
  input  logic [ADDR_W-1:0]             i_j_field,
  input  logic [$clog2(NUM_COND)-1:0]   i_cond_sel,
  input  logic [$clog2(ADDR_W)-1:0]     i_cond_bit,
  input  logic [NUM_COND-1:0]           i_cond,
  input  logic [OPC_W-1:0]              i_opcode,
  output logic [ADDR_W-1:0]             o_upc,
  output logic [ADDR_W-1:0]             o_next_addr,
  output logic [$clog2(STACK_DEPTH):0]  o_depth,
  output logic                          o_stack_ovf,
  output logic                          o_stack_unf
);

  localparam int SEL_W = $clog2(NUM_COND);

  logic              push_req, pop_req;
  logic              stack_full, stack_empty;
  logic [ADDR_W-1:0] stack_top, cond_mask, upc_inc;
  logic [SEL_W:0]    sel_ext;
  logic              cond_true;

  assign sel_ext   = {1'b0, i_cond_sel};
  assign cond_true = (sel_ext < (SEL_W+1)'(NUM_COND)) ? i_cond[i_cond_sel] : 1'b0;
  // Shift amounts past the top bit fall off, leaving the base address unchanged.
  assign cond_mask = cond_true ? (ADDR_W'(1) << i_cond_bit) : '0;
  assign upc_inc   = o_upc + ADDR_W'(1);

  always_comb begin
    o_next_addr = i_j_field;
    push_req    = 1'b0;
    pop_req     = 1'b0;
    case (i_mode)
      MODE_COND:     o_next_addr = i_j_field | cond_mask;
      MODE_DISPATCH: o_next_addr = ADDR_W'(i_opcode);
      MODE_CALL:     push_req    = 1'b1;
      MODE_RET: begin
        pop_req     = 1'b1;
        o_next_addr = stack_empty ? ADDR_W'(RESET_ADDR) : stack_top;
      end
      default: ;
    endcase
  end

  useq_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req & ~i_stall),
    .pop       (pop_req & ~i_stall),
    .push_data (upc_inc),
    .top       (stack_top),
    .depth     (o_depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_upc       <= ADDR_W'(RESET_ADDR);
      o_stack_ovf <= 1'b0;
      o_stack_unf <= 1'b0;
    end else if (!i_stall) begin
      o_upc <= o_next_addr;
      if (push_req && stack_full) o_stack_ovf <= 1'b1;
      if (pop_req && stack_empty) o_stack_unf <= 1'b1;
    end
  end

endmodule

// File: doc/micro_pc_unit.md
MICRO_PC_UNIT -- requirements
Module: micro_pc_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, 6, micro-address width in bits.
REQ-003 Parameter NUM_COND, 8, number of condition inputs.
REQ-004 Parameter OPC_W, 4, opcode width used for dispatch.
REQ-005 Parameter STACK_DEPTH, 4, return-stack entries (power of 2, at least 2).
REQ-006 Parameter RESET_ADDR, 18, micro-address loaded on reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 i_stall  input  1  hold uPC and stack this cycle.
REQ-010 i_mode  input  3  next-address mode (encodings per REQ-017).
REQ-011 i_j_field  input  ADDR_W  base or target micro-address.
REQ-012 i_cond_sel  input  clog2(NUM_COND)  selects one condition input.
REQ-013 i_cond_bit  input  clog2(ADDR_W)  bit of i_j_field ORed when the condition is true.
REQ-014 i_cond  input  NUM_COND  condition vector (R, BEN, ACV, PSR_15, INT, ...).
REQ-015 i_opcode  input  OPC_W  instruction opcode for dispatch.
REQ-016 Outputs: o_upc ADDR_W current state; o_next_addr ADDR_W combinational next address; o_depth clog2(STACK_DEPTH)+1 stack occupancy; o_stack_ovf 1 and o_stack_unf 1 sticky error flags.

Function
REQ-017 Modes SHALL be: 000 JUMP, 001 COND, 010 DISPATCH, 011 CALL, 100 RET; 101-111 SHALL behave as JUMP.
REQ-018 JUMP: next = i_j_field.
REQ-019 COND: next = i_j_field OR (i_cond[i_cond_sel] << i_cond_bit).
REQ-020 DISPATCH: next = opcode zero-extended to ADDR_W; if OPC_W >= ADDR_W, next = the low ADDR_W bits of the opcode.
REQ-021 CALL: push (o_upc + 1) mod 2^ADDR_W, then next = i_j_field.
REQ-022 RET: pop the top entry; next = the popped value.
REQ-023 o_upc SHALL register o_next_addr on every rising edge when rst=0 and i_stall=0, giving 1-cycle latency.
REQ-024 Priority SHALL be rst > i_stall > mode; a stalled cycle SHALL change no state and no flags.
REQ-025 o_next_addr SHALL reflect the mode decode even while i_stall=1.
REQ-026 CALL with the stack full SHALL discard the push, set o_stack_ovf, leave o_depth unchanged and still jump to i_j_field.
REQ-027 RET with the stack empty SHALL set o_stack_unf and load RESET_ADDR.
REQ-028 o_upc + 1 at 2^ADDR_W-1 SHALL wrap to 0.
REQ-029 The error flags SHALL be sticky until reset.
REQ-030 Out-of-range i_cond_sel (value >= NUM_COND) SHALL read as condition false.

Reset
REQ-031 On rst=1 at a clock edge: o_upc = RESET_ADDR, o_depth = 0, o_stack_ovf = 0, o_stack_unf = 0, all stack entries = 0.
REQ-032 Reset asserted mid-sequence SHALL abandon any pending call context in the same edge.

Structure
REQ-033 Mode encodings and the default parameter constants SHALL live in shared package useq_pkg.
REQ-034 The return stack SHALL be the sub-module useq_stack, which holds push/pop, depth and the full/empty flags.
REQ-035 The next-address mux SHALL be combinational and live in micro_pc_unit.

Verification
REQ-036 Release reset, JUMP j=33 -> o_upc=18 after reset, then 33 one cycle later.
REQ-037 COND with cond_sel=R, cond_bit=1, j=28: R=0 for 3 cycles gives o_upc=28 on each of those cycles; R=1 gives o_upc=30.
REQ-038 DISPATCH with opcode=0001 -> o_upc=1; with opcode=1111 -> o_upc=15.
REQ-039 From uPC=10, CALL j=40 then RET -> o_upc=40 then 11, with o_depth going 1 then 0.
REQ-040 Five CALLs with STACK_DEPTH=4 -> o_stack_ovf=1 and o_depth=4; five RETs -> the 5th returns 18 with o_stack_unf=1.
REQ-041 i_stall=1 during a CALL, and reset asserted mid-stack -> o_upc and o_depth are held while stalled; reset returns o_upc=18, o_depth=0 and both error flags to 0.
